xbar_slave_ram: RTL and testbench



---
 rtl/xbar_slave_ram.sv | 158 +++++++++++++++
 tb/tb_xbar_slave_ram.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_slave_ram.sv
// Crossbar slave endpoint backed by a word-addressed RAM.
// Returns a one-cycle ack and then a one-cycle resp, with the latencies set by parameters.
module xbar_slave_ram #(
  parameter int ADDR_W   = 30,
  parameter int DEPTH    = 1024,
  parameter int ACK_LAT  = 1,
  parameter int RESP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic              resp,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;

  localparam logic [3:0] ACK_LOAD  = 4'(ACK_LAT - 1);
  localparam logic [3:0] RESP_LOAD = 4'(RESP_LAT - 1);

  if ((ACK_LAT < 1) || (ACK_LAT > 15)) begin : g_bad_ack_lat
    $fatal(1, "xbar_slave_ram: ACK_LAT must lie in 1..15");
  end
  if ((RESP_LAT < 1) || (RESP_LAT > 15)) begin : g_bad_resp_lat
    $fatal(1, "xbar_slave_ram: RESP_LAT must lie in 1..15");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "xbar_slave_ram: DEPTH must be a power of two");
  end
  if (ADDR_W < IDX_W) begin : g_bad_addr_w
    $fatal(1, "xbar_slave_ram: ADDR_W too narrow for DEPTH");
  end

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_cmd;
  logic [IDX_W-1:0] r_addr;
  logic [31:0]      r_wdata;
  logic             r_ack;
  logic             r_resp;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH];

  logic [1:0]       w_state_next;
  logic [3:0]       w_cnt_next;
  logic             w_accept;
  logic             w_viol;
  logic             w_ack_next;
  logic             w_resp_next;
  logic             w_mem_we;
  logic             w_unused_addr_bits;

  // Address bits above the RAM index are deliberately dropped (aliasing).
  assign w_unused_addr_bits = ^addr;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT_ACK;
          w_cnt_next   = ACK_LOAD;
        end
      end
      S_WAIT_ACK: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_WAIT_RESP;
          w_cnt_next   = RESP_LOAD;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_WAIT_RESP: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // The pulse cycles are "WAIT_ACK, count 0" and "WAIT_RESP, count 0";
  // decoding them from the next state lets ack/resp come straight from flops.
  assign w_viol      = req && (r_state != S_IDLE);
  assign w_ack_next  = (w_state_next == S_WAIT_ACK)  && (w_cnt_next == 4'd0);
  assign w_resp_next = (w_state_next == S_WAIT_RESP) && (w_cnt_next == 4'd0);
  assign w_mem_we    = w_resp_next && r_cmd && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_cmd   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_ack   <= 1'b0;
      r_resp  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= w_ack_next;
      r_resp  <= w_resp_next;
      if (w_accept) begin
        r_cmd   <= cmd;
        r_addr  <= addr[IDX_W-1:0];
        r_wdata <= wdata;
      end
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Registered read port; rdata only changes on the edge that raises resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (w_resp_next) begin
      if (r_cmd) begin
        r_rdata <= 32'd0;
      end else begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

  assign ack   = r_ack;
  assign resp  = r_resp;
  assign rdata = r_rdata;
  assign err   = r_err;

endmodule

// File: tb/tb_xbar_slave_ram.sv
// Bench for xbar_slave_ram: two instances (latencies 1/2 and 3/5) checked against
// a plain array memory model and cycle numbers counted from each request.
module tb_xbar_slave_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        req_s   [2];
  logic        cmd_s   [2];
  logic [29:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        ack_s   [2];
  logic        resp_s  [2];
  logic [31:0] rdata_s [2];
  logic        err_s   [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m   [2][1024];
  bit          known_m [2][1024];
  bit          err_m   [2];

  xbar_slave_ram #(.ADDR_W(30), .DEPTH(1024), .ACK_LAT(1), .RESP_LAT(2)) dut_a (
    .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .cmd(cmd_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .ack(ack_s[0]), .resp(resp_s[0]), .rdata(rdata_s[0]), .err(err_s[0])
  );

  xbar_slave_ram #(.ADDR_W(30), .DEPTH(1024), .ACK_LAT(3), .RESP_LAT(5)) dut_b (
    .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .cmd(cmd_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .ack(ack_s[1]), .resp(resp_s[1]), .rdata(rdata_s[1]), .err(err_s[1])
  );

  function automatic int ack_lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int resp_lat(input int d);
    return (d == 0) ? 2 : 5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request (cycle 0) and records when ack/resp were seen, counted from it.
  task automatic drive_txn(input int d, input bit wr, input logic [29:0] a, input logic [31:0] wd,
                           input int viol_k, input logic [29:0] va, input logic [31:0] vd,
                           input int rst_k, input int tail,
                           output int ack_n, output int ack_k, output int resp_n, output int resp_k,
                           output logic [31:0] rd);
    int last;
    last   = ack_lat(d) + resp_lat(d) + tail;
    ack_n  = 0;
    ack_k  = -1;
    resp_n = 0;
    resp_k = -1;
    rd     = 32'd0;
    step();
    req_s[d]   = 1'b1;
    cmd_s[d]   = wr;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    for (int k = 1; k <= last; k++) begin
      step();
      req_s[d] = (k == viol_k);
      if (k == viol_k) begin
        cmd_s[d]   = 1'b1;
        addr_s[d]  = va;
        wdata_s[d] = vd;
      end
      rst_s[d] = (k == rst_k);
      if (ack_s[d]) begin
        ack_n++;
        if (ack_k < 0) ack_k = k;
      end
      if (resp_s[d]) begin
        resp_n++;
        if (resp_k < 0) begin
          resp_k = k;
          rd     = rdata_s[d];
        end
      end
    end
    req_s[d] = 1'b0;
    rst_s[d] = 1'b0;
    $display("txn dut%0d %s addr=%h wdata=%h ack@%0d resp@%0d rdata=%h",
             d, wr ? "WR" : "RD", a, wd, ack_k, resp_k, rd);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; req_s[d] = 1'b0; cmd_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ack_s[d], resp_s[d], err_s[d]} !== 3'b000 || rdata_s[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_in_dut%0d ack/resp/err=%b%b%b rdata=%h required 000 and 0",
                 d, ack_s[d], resp_s[d], err_s[d], rdata_s[d]);
      end
      rst_s[d] = 1'b0;
    end
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ack_s[d], resp_s[d], err_s[d]} !== 3'b000 || rdata_s[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_after_dut%0d ack/resp/err=%b%b%b rdata=%h required 000 and 0",
                 d, ack_s[d], resp_s[d], err_s[d], rdata_s[d]);
      end
    end
  endtask

  task automatic test_write_read();
    int an, ak, rn, rk;
    logic [31:0] rd, v;
    drive_txn(0, 1'b1, 30'h005, 32'hDEADBEEF, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    mem_m[0][5] = 32'hDEADBEEF; known_m[0][5] = 1'b1;
    checks++;
    if (an !== 1 || ak !== 1) begin
      errors++; $display("FAIL wr_ack count=%0d cycle=%0d required 1 and 1", an, ak);
    end
    checks++;
    if (rn !== 1 || rk !== 3) begin
      errors++; $display("FAIL wr_resp count=%0d cycle=%0d required 1 and 3", rn, rk);
    end
    checks++;
    if (rd !== 32'd0 || err_s[0] !== 1'b0) begin
      errors++; $display("FAIL wr_rdata_err rdata=%h err=%b required 0 and 0", rd, err_s[0]);
    end
    for (int i = 0; i < 2; i++) begin
      drive_txn(0, 1'b0, 30'h005, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
      checks++;
      if (an !== 1 || ak !== 1 || rn !== 1 || rk !== 3 || rd !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL readback%0d ack=%0d@%0d resp=%0d@%0d rdata=%h required 1@1 1@3 deadbeef",
                 i, an, ak, rn, rk, rd);
      end
    end
    v = $urandom;
    drive_txn(0, 1'b1, 30'h00A, v, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    mem_m[0][10] = v; known_m[0][10] = 1'b1;
    drive_txn(0, 1'b0, 30'h00A, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rk !== 3 || rd !== v) begin
      errors++; $display("FAIL read_after_write resp@%0d rdata=%h required 3 and %h", rk, rd, v);
    end
  endtask

  task automatic test_alias();
    int an, ak, rn, rk;
    logic [31:0] rd;
    logic [29:0] hi;
    drive_txn(0, 1'b1, 30'h405, 32'h12345678, -1, '0, '0, -1, 1, an, ak, rn, rk, rd);
    mem_m[0][5] = 32'h12345678;
    drive_txn(0, 1'b0, 30'h005, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++; $display("FAIL alias_low rdata=%h required 12345678", rd);
    end
    hi = {20'($urandom), 10'h005};
    drive_txn(0, 1'b0, hi, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++; $display("FAIL alias_high addr=%h rdata=%h required 12345678", hi, rd);
    end
  endtask

  task automatic test_latency();
    int an, ak, rn, rk;
    logic [31:0] rd, v;
    logic [29:0] a;
    a = {20'($urandom), 10'h0C3};
    v = $urandom;
    drive_txn(1, 1'b1, a, v, -1, '0, '0, -1, 2, an, ak, rn, rk, rd);
    mem_m[1][a[9:0]] = v; known_m[1][a[9:0]] = 1'b1;
    checks++;
    if (an !== 1 || ak !== 3) begin
      errors++; $display("FAIL lat_ack count=%0d cycle=%0d required 1 and 3", an, ak);
    end
    checks++;
    if (rn !== 1 || rk !== 8 || rd !== 32'd0) begin
      errors++; $display("FAIL lat_resp count=%0d cycle=%0d rdata=%h required 1, 8, 0", rn, rk, rd);
    end
    drive_txn(1, 1'b0, a, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rk !== 8 || rd !== v) begin
      errors++; $display("FAIL lat_read resp@%0d rdata=%h required 8 and %h", rk, rd, v);
    end
  endtask

  task automatic test_random();
    int an, ak, rn, rk, d, tail;
    bit wr;
    logic [31:0] rd, v, exp_rd;
    logic [29:0] a;
    for (int n = 0; n < 40; n++) begin
      d    = $urandom_range(0, 1);
      a    = {20'($urandom), 10'($urandom_range(0, 31))};
      wr   = 1'($urandom_range(0, 1));
      if (!known_m[d][a[9:0]]) wr = 1'b1;
      v    = $urandom;
      tail = $urandom_range(0, 2);
      exp_rd = wr ? 32'd0 : mem_m[d][a[9:0]];
      drive_txn(d, wr, a, v, -1, '0, '0, -1, tail, an, ak, rn, rk, rd);
      if (wr) begin
        mem_m[d][a[9:0]] = v; known_m[d][a[9:0]] = 1'b1;
      end
      checks++;
      if (an !== 1 || ak !== ack_lat(d) || rn !== 1 || rk !== ack_lat(d) + resp_lat(d)) begin
        errors++;
        $display("FAIL rand%0d_timing ack=%0d@%0d resp=%0d@%0d required 1@%0d 1@%0d",
                 n, an, ak, rn, rk, ack_lat(d), ack_lat(d) + resp_lat(d));
      end
      checks++;
      if (rd !== exp_rd || err_s[d] !== err_m[d]) begin
        errors++;
        $display("FAIL rand%0d_data rdata=%h err=%b required %h and %b", n, rd, err_s[d], exp_rd, err_m[d]);
      end
    end
  endtask

  task automatic test_violation();
    int an, ak, rn, rk;
    logic [31:0] rd, p, exp5;
    logic [29:0] a;
    p = $urandom;
    drive_txn(0, 1'b1, 30'h006, p, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    mem_m[0][6] = p; known_m[0][6] = 1'b1;
    exp5 = mem_m[0][5];
    drive_txn(0, 1'b0, 30'h005, '0, 2, 30'h006, 32'hAAAA5555, -1, 1, an, ak, rn, rk, rd);
    err_m[0] = 1'b1;
    checks++;
    if (an !== 1 || ak !== 1 || rn !== 1 || rk !== 3) begin
      errors++; $display("FAIL viol_timing ack=%0d@%0d resp=%0d@%0d required 1@1 1@3", an, ak, rn, rk);
    end
    checks++;
    if (rd !== exp5 || err_s[0] !== 1'b1) begin
      errors++; $display("FAIL viol_result rdata=%h err=%b required %h and 1", rd, err_s[0], exp5);
    end
    drive_txn(0, 1'b0, 30'h006, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rd !== p || err_s[0] !== 1'b1) begin
      errors++; $display("FAIL viol_ignored rdata=%h err=%b required %h and 1", rd, err_s[0], p);
    end
    // Request landing in the resp cycle itself must also be refused.
    a = {20'($urandom), 10'h1F0};
    p = $urandom;
    drive_txn(1, 1'b1, a, p, 8, 30'h1F0, 32'hAAAA5555, -1, 1, an, ak, rn, rk, rd);
    mem_m[1][10'h1F0] = p; known_m[1][10'h1F0] = 1'b1;
    err_m[1] = 1'b1;
    checks++;
    if (rn !== 1 || rk !== 8 || err_s[1] !== 1'b1) begin
      errors++; $display("FAIL viol_resp_cycle resp=%0d@%0d err=%b required 1@8 and 1", rn, rk, err_s[1]);
    end
    drive_txn(1, 1'b0, 30'h1F0, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rd !== p || rk !== 8 || err_s[1] !== 1'b1) begin
      errors++; $display("FAIL viol_resp_readback rdata=%h resp@%0d err=%b required %h, 8, 1", rd, rk, err_s[1], p);
    end
  endtask

  task automatic test_mid_reset();
    int an, ak, rn, rk;
    logic [31:0] rd, v;
    drive_txn(0, 1'b1, 30'h007, 32'h01020304, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    mem_m[0][7] = 32'h01020304; known_m[0][7] = 1'b1;
    drive_txn(0, 1'b1, 30'h007, 32'h0BADF00D, -1, '0, '0, 2, 3, an, ak, rn, rk, rd);
    err_m[0] = 1'b0;
    checks++;
    if (an !== 1 || ak !== 1 || rn !== 0) begin
      errors++; $display("FAIL midrst_pulses ack=%0d@%0d resp=%0d required 1@1 and 0", an, ak, rn);
    end
    checks++;
    if ({ack_s[0], resp_s[0], err_s[0]} !== 3'b000 || rdata_s[0] !== 32'd0) begin
      errors++;
      $display("FAIL midrst_outputs ack/resp/err=%b%b%b rdata=%h required 000 and 0",
               ack_s[0], resp_s[0], err_s[0], rdata_s[0]);
    end
    drive_txn(0, 1'b0, 30'h007, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rd !== 32'h01020304 || rk !== 3) begin
      errors++; $display("FAIL midrst_no_write rdata=%h resp@%0d required 01020304 and 3", rd, rk);
    end
    // Reset during the resp cycle: the write has already landed.
    v = $urandom;
    drive_txn(1, 1'b1, 30'h2A2, v, -1, '0, '0, 8, 2, an, ak, rn, rk, rd);
    mem_m[1][10'h2A2] = v; known_m[1][10'h2A2] = 1'b1;
    err_m[1] = 1'b0;
    checks++;
    if (rn !== 1 || rk !== 8 || err_s[1] !== 1'b0 || rdata_s[1] !== 32'd0) begin
      errors++;
      $display("FAIL rst_in_resp resp=%0d@%0d err=%b rdata=%h required 1@8, 0, 0", rn, rk, err_s[1], rdata_s[1]);
    end
    drive_txn(1, 1'b0, 30'h2A2, '0, -1, '0, '0, -1, 0, an, ak, rn, rk, rd);
    checks++;
    if (rd !== v) begin
      errors++; $display("FAIL rst_in_resp_readback rdata=%h required %h", rd, v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; req_s[d] = 1'b0; cmd_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
      err_m[d] = 1'b0;
      for (int i = 0; i < 1024; i++) begin
        known_m[d][i] = 1'b0;
        mem_m[d][i]   = 32'd0;
      end
    end
    test_reset();
    test_write_read();
    test_alias();
    test_latency();
    test_random();
    test_violation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
